debounce_scheduler: RTL and testbench
=====================================

# debounce_scheduler

Debounces N noisy push-button inputs with one shared settle counter instead of one counter per button. A round-robin scanner finds a channel whose synchronized input disagrees with its clean state and grants it the counter. The granted channel commits its new level only after DELAY+1 stable cycles. The block sits between the board button pins and the lab control logic, and supplies clean levels plus one-cycle press/release pulses.

## Interface
- N, 4: number of button channels (N ≥ 2).
- DELAY, 100000: stable cycles required before commit, minus one.
- CW, 17: counter width; requires 2^CW > DELAY.
- IW, $clog2(N): channel index width.

- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; sampled only on rising clk edges.
- b_noise  in  N  raw asynchronous button levels.
- b_clean  out  N  debounced levels (registered).
- press  out  N  one-cycle pulse on a committed 0→1 transition.
- release  out  N  one-cycle pulse on a committed 1→0 transition.
- busy  out  1  high while the counter is granted (state COUNT).
- owner  out  IW  channel currently scanned or granted (= ptr).

## Operation
- Each b_noise bit passes through a 2-FF synchronizer, giving s[i]. Debounce logic sees only s.
- Registers: state {SCAN, COUNT}, ptr (IW bits), count (CW bits), b_clean, press, release.
- Reset values: state=SCAN, ptr=0, count=0, b_clean=0, press=0, release=0, synchronizer flops=0, busy=0, owner=0.
- Default every cycle: press=0, release=0.
- SCAN, with s[ptr]==b_clean[ptr]: ptr ← ptr+1 mod N. Wraps N-1→0 for any N, not only powers of two.
- SCAN, with s[ptr]!=b_clean[ptr]: state ← COUNT, count ← 0, ptr held.
- COUNT, with s[ptr]==b_clean[ptr] (bounce back): abort. count ← 0, state ← SCAN, ptr ← ptr+1. No output change.
- COUNT, with count==DELAY: b_clean[ptr] ← s[ptr]. press[ptr] ← s[ptr]; release[ptr] ← ~s[ptr]. count ← 0, state ← SCAN, ptr ← ptr+1.
- COUNT, otherwise: count ← count+1. Never exceeds DELAY, so no wrap.
- Channels other than ptr are ignored while COUNT is active; their mismatches wait for the scan.
- Only one channel commits per cycle, so at most one bit of press|release is ever set.
- busy = (state==COUNT); owner = ptr. Both are combinational from registers.

## Timing
- Synchronizer latency: 2 cycles.
- Stable run: the SCAN cycle detecting a mismatch on ptr is followed by DELAY+1 COUNT cycles. b_clean and the pulse update on the edge ending the COUNT cycle with count==DELAY.
- Worst-case latency from a b_noise change to commit, with no competing channels: 2 + N + DELAY + 1 cycles.
- A channel waiting behind the owner waits up to one full grant (DELAY+2 cycles) per preceding channel.
- A bounce of any length ≤ DELAY cycles during COUNT aborts the grant and produces no output change.
- Reset mid-COUNT: the next edge forces all reset values. The partial count is discarded and b_clean returns to 0, even if previously 1.
- press and release are exactly one cycle wide and coincide with the b_clean update edge.

## Structure
- Package debounce_pkg: state enum (SCAN, COUNT) and the default DELAY constant.
- Sub-module btn_sync: 2-FF synchronizer with clk and reset, instantiated N times (or with a width parameter N).
- Keep the scanner FSM, counter and output registers in a single always block with the synchronous reset branch first.

## Test plan
All scenarios use N=4 and DELAY=4.
- Reset: hold reset 3 cycles with b_noise=4'hF → b_clean=0, press=release=0, busy=0, owner=0 throughout. After release, owner steps 0,1,2,3,0.
- Clean press: b_noise[2] 0→1 and held → busy goes high with owner=2. Exactly one press[2] pulse follows; b_clean[2]=1 within 2+4+5 cycles of the change and stays there.
- Bounce: b_noise[1] high for 3 cycles, then low → busy rises then drops via the abort path. No press or release pulse, b_clean=0.
- Simultaneous press: b_noise[0] and b_noise[3] rise on the same edge → press[0] fires first, press[3] later. The two pulses are separated by at least DELAY+2 cycles and never overlap.
- Release: with b_clean[1]=1, drop b_noise[1] and hold → exactly one release[1] pulse, b_clean[1]=0, press stays 0.
- Reset mid-operation: assert reset when count=2 on channel 3 → state SCAN, count 0 and b_clean=0 next cycle, with no pulse. Channel 3 then re-debounces from scratch after reset deasserts.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the round-robin button debouncer.
package debounce_pkg;

  typedef enum logic {
    SCAN  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int DEFAULT_DELAY = 100000;

endpackage

// File: rtl/debounce_scheduler_btn_sync.sv
// Two-flop synchronizer that brings one raw button pin into the clk domain.
module btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/debounce_scheduler.sv
// Round-robin debouncer: one shared settle counter is lent to whichever
// channel the scanner finds disagreeing with its clean level.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int N     = 4,
  parameter int DELAY = DEFAULT_DELAY,
  parameter int CW    = 17,
  parameter int IW    = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  b_noise,
  output logic [N-1:0]  b_clean,
  output logic [N-1:0]  press,
  // 'release' is a reserved word, hence the suffix.
  output logic [N-1:0]  release_pulse,
  output logic          busy,
  output logic [IW-1:0] owner
);

  logic [N-1:0]  s;
  state_t        state_reg,   state_next;
  logic [IW-1:0] ptr_reg,     ptr_next;
  logic [CW-1:0] count_reg,   count_next;
  logic [N-1:0]  b_clean_reg, b_clean_next;
  logic [N-1:0]  press_reg,   press_next;
  logic [N-1:0]  release_reg, release_next;
  logic [IW-1:0] ptr_inc;
  logic          mismatch;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_sync
      btn_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (b_noise[gi]),
        .q     (s[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= SCAN;
      ptr_reg     <= '0;
      count_reg   <= '0;
      b_clean_reg <= '0;
      press_reg   <= '0;
      release_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      count_reg   <= count_next;
      b_clean_reg <= b_clean_next;
      press_reg   <= press_next;
      release_reg <= release_next;
    end
  end

  // Explicit wrap so non-power-of-two channel counts stay in range.
  assign ptr_inc  = (ptr_reg == IW'(N - 1)) ? '0 : ptr_reg + IW'(1);
  assign mismatch = (s[ptr_reg] != b_clean_reg[ptr_reg]);

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    count_next   = count_reg;
    b_clean_next = b_clean_reg;
    press_next   = '0;
    release_next = '0;
    case (state_reg)
      SCAN: begin
        if (mismatch) begin
          state_next = COUNT;
          count_next = '0;
        end else begin
          ptr_next = ptr_inc;
        end
      end
      COUNT: begin
        if (!mismatch) begin
          // Input bounced back to the clean level: give up the grant silently.
          state_next = SCAN;
          count_next = '0;
          ptr_next   = ptr_inc;
        end else if (count_reg == CW'(DELAY)) begin
          b_clean_next[ptr_reg] = s[ptr_reg];
          press_next[ptr_reg]   = s[ptr_reg];
          release_next[ptr_reg] = ~s[ptr_reg];
          state_next            = SCAN;
          count_next            = '0;
          ptr_next              = ptr_inc;
        end else begin
          count_next = count_reg + CW'(1);
        end
      end
      default: begin
        state_next = SCAN;
      end
    endcase
  end

  always_comb begin
    busy          = (state_reg == COUNT);
    owner         = ptr_reg;
    b_clean       = b_clean_reg;
    press         = press_reg;
    release_pulse = release_reg;
  end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with N=4, DELAY=4; the scanner phase
// is tracked by hand so every pulse and grant lands on a known cycle.
module tb_debounce_scheduler;

  localparam int N     = 4;
  localparam int DELAY = 4;
  localparam int CW    = 17;
  localparam int IW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  b_noise;
  logic [N-1:0]  b_clean;
  logic [N-1:0]  press;
  logic [N-1:0]  release_pulse;
  logic          busy;
  logic [IW-1:0] owner;

  int tests = 0;
  int fails = 0;

  int cyc;
  int press_cnt[N];
  int rel_cnt[N];
  int first_press[N];
  int first_rel[N];
  int first_busy;
  int first_owner;
  int busy_fall;
  int multi;

  debounce_scheduler #(
    .N     (N),
    .DELAY (DELAY),
    .CW    (CW),
    .IW    (IW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .b_noise       (b_noise),
    .b_clean       (b_clean),
    .press         (press),
    .release_pulse (release_pulse),
    .busy          (busy),
    .owner         (owner)
  );

  always #5 clk = ~clk;

  task automatic clear_stats();
    cyc         = 0;
    first_busy  = -1;
    first_owner = -1;
    busy_fall   = -1;
    multi       = 0;
    for (int i = 0; i < N; i++) begin
      press_cnt[i]   = 0;
      rel_cnt[i]     = 0;
      first_press[i] = -1;
      first_rel[i]   = -1;
    end
  endtask

  // Advance n cycles, sampling outputs on each falling edge.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (press[i]) begin
          press_cnt[i]++;
          if (first_press[i] < 0) first_press[i] = cyc;
        end
        if (release_pulse[i]) begin
          rel_cnt[i]++;
          if (first_rel[i] < 0) first_rel[i] = cyc;
        end
      end
      if (busy && first_busy < 0) begin
        first_busy  = cyc;
        first_owner = int'(owner);
      end
      if (!busy && first_busy >= 0 && busy_fall < 0) busy_fall = cyc;
      if ($countones(press | release_pulse) > 1) multi++;
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    b_noise = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (b_clean !== 4'h0 || press !== 4'h0 || release_pulse !== 4'h0 ||
          busy !== 1'b0 || owner !== 2'd0) begin
        fails++;
        $display("FAIL reset_hold cyc%0d: b_clean=%h press=%h rel=%h busy=%b owner=%0d required 0,0,0,0,0",
                 k, b_clean, press, release_pulse, busy, owner);
      end
    end
    reset   = 1'b0;
    b_noise = 4'h0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) @(negedge clk);
      tests++;
      if (owner !== 2'(k % 4) || busy !== 1'b0) begin
        fails++;
        $display("FAIL owner_step k=%0d: owner=%0d busy=%b required owner=%0d busy=0",
                 k, owner, busy, k % 4);
      end
    end
    $display("[TB] test_reset done");
  endtask

  // Scanner at ptr=0: channel 2 granted on cycle 3, commits on cycle 8.
  task automatic test_clean_press();
    clear_stats();
    b_noise = 4'b0100;
    run(12);
    tests++;
    if (first_busy != 3 || first_owner != 2) begin
      fails++;
      $display("FAIL press_grant: busy at cyc %0d owner %0d required cyc 3 owner 2", first_busy, first_owner);
    end
    tests++;
    if (press_cnt[2] != 1 || first_press[2] != 8) begin
      fails++;
      $display("FAIL press_pulse: count %0d at cyc %0d required 1 at cyc 8", press_cnt[2], first_press[2]);
    end
    tests++;
    if (b_clean !== 4'b0100 || rel_cnt[2] != 0 || press_cnt[0] + press_cnt[1] + press_cnt[3] != 0) begin
      fails++;
      $display("FAIL press_clean: b_clean=%h rel2=%0d other_press=%0d required 0100,0,0",
               b_clean, rel_cnt[2], press_cnt[0] + press_cnt[1] + press_cnt[3]);
    end
    $display("[TB] test_clean_press done: press[2] at cyc %0d", first_press[2]);
  endtask

  // Scanner at ptr=3: channel 1 high 3 cycles, grant cycles 3..5, abort on 6.
  task automatic test_bounce();
    clear_stats();
    b_noise = 4'b0110;
    run(3);
    b_noise = 4'b0100;
    run(11);
    tests++;
    if (first_busy != 3 || first_owner != 1 || busy_fall != 6) begin
      fails++;
      $display("FAIL bounce_abort: busy %0d..%0d owner %0d required 3..6 owner 1", first_busy, busy_fall, first_owner);
    end
    tests++;
    if (press_cnt[1] != 0 || rel_cnt[1] != 0 || b_clean !== 4'b0100) begin
      fails++;
      $display("FAIL bounce_quiet: press1=%0d rel1=%0d b_clean=%h required 0,0,0100",
               press_cnt[1], rel_cnt[1], b_clean);
    end
    $display("[TB] test_bounce done");
  endtask

  // Scanner at ptr=2: channel 0 commits on cycle 8, channel 3 on cycle 16.
  task automatic test_simultaneous();
    clear_stats();
    b_noise = 4'b1101;
    run(20);
    tests++;
    if (press_cnt[0] != 1 || first_press[0] != 8) begin
      fails++;
      $display("FAIL simul_press0: count %0d at cyc %0d required 1 at cyc 8", press_cnt[0], first_press[0]);
    end
    tests++;
    if (press_cnt[3] != 1 || first_press[3] != 16) begin
      fails++;
      $display("FAIL simul_press3: count %0d at cyc %0d required 1 at cyc 16", press_cnt[3], first_press[3]);
    end
    tests++;
    if (first_press[3] - first_press[0] < DELAY + 2 || multi != 0) begin
      fails++;
      $display("FAIL simul_gap: gap %0d overlaps %0d required gap>=%0d overlaps 0",
               first_press[3] - first_press[0], multi, DELAY + 2);
    end
    tests++;
    if (b_clean !== 4'b1101) begin
      fails++;
      $display("FAIL simul_clean: b_clean=%h required 1101", b_clean);
    end
    $display("[TB] test_simultaneous done: press[0]@%0d press[3]@%0d", first_press[0], first_press[3]);
  endtask

  // Press channel 1 (commit cycle 11), then release it (commit cycle 10).
  task automatic test_release();
    clear_stats();
    b_noise = 4'b1111;
    run(14);
    tests++;
    if (press_cnt[1] != 1 || first_press[1] != 11 || b_clean !== 4'b1111) begin
      fails++;
      $display("FAIL rel_setup: press1 %0d at cyc %0d b_clean=%h required 1 at 11, 1111",
               press_cnt[1], first_press[1], b_clean);
    end
    clear_stats();
    b_noise = 4'b1101;
    run(14);
    tests++;
    if (rel_cnt[1] != 1 || first_rel[1] != 10) begin
      fails++;
      $display("FAIL rel_pulse: count %0d at cyc %0d required 1 at cyc 10", rel_cnt[1], first_rel[1]);
    end
    tests++;
    if (b_clean !== 4'b1101 || press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] != 0) begin
      fails++;
      $display("FAIL rel_state: b_clean=%h press_total=%0d required 1101,0", b_clean,
               press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]);
    end
    $display("[TB] test_release done: release[1] at cyc %0d", first_rel[1]);
  endtask

  // Scanner at ptr=2: channel 3 drops, reaches count=2 after cycle 8, then reset.
  task automatic test_reset_mid();
    clear_stats();
    b_noise = 4'b0101;
    run(8);
    tests++;
    if (busy !== 1'b1 || owner !== 2'd3 || first_busy != 6) begin
      fails++;
      $display("FAIL midrst_setup: busy=%b owner=%0d first_busy=%0d required 1,3,6", busy, owner, first_busy);
    end
    reset   = 1'b1;
    b_noise = 4'b1000;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || owner !== 2'd0 || b_clean !== 4'h0 || press !== 4'h0 || release_pulse !== 4'h0) begin
      fails++;
      $display("FAIL midrst_state: busy=%b owner=%0d b_clean=%h press=%h rel=%h required 0,0,0,0,0",
               busy, owner, b_clean, press, release_pulse);
    end
    reset = 1'b0;
    clear_stats();
    run(12);
    tests++;
    if (first_busy != 4 || first_owner != 3) begin
      fails++;
      $display("FAIL midrst_regrant: busy at cyc %0d owner %0d required cyc 4 owner 3", first_busy, first_owner);
    end
    tests++;
    if (press_cnt[3] != 1 || first_press[3] != 9 || b_clean !== 4'b1000 || rel_cnt[3] != 0) begin
      fails++;
      $display("FAIL midrst_commit: press3 %0d at cyc %0d b_clean=%h rel3=%0d required 1 at 9, 1000, 0",
               press_cnt[3], first_press[3], b_clean, rel_cnt[3]);
    end
    $display("[TB] test_reset_mid done: press[3] at cyc %0d", first_press[3]);
  endtask

  initial begin
    reset   = 1'b1;
    b_noise = 4'hF;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_release();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
